// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Single-port VRAM arbiter between a video scanout reader and a
//             CPU. Video has priority, except that after STARVE_MAX consecutive
//             CPU denials the CPU is forced through for one access. Grants are
//             combinational, and RAM address/control are driven in the ACK
//             cycle. Read data returns one cycle later with a VALID pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH       number of addressable VRAM bytes (addresses >= DEPTH are void)
//    STARVE_MAX  consecutive CPU denials before the CPU wins (1..255)
//  Ports
//    CLK_25MHZ   in   1   clock, rising edge
//    RESET_N     in   1   synchronous active-low reset
//    VID_REQ     in   1   video read request, held until VID_ACK
//    VID_ADDR    in  13   video read byte address
//    VID_ACK     out  1   video granted this cycle
//    VID_VALID   out  1   VID_DATA carries fresh read data
//    VID_DATA    out  8   video read data (held between VALID pulses)
//    CPU_REQ     in   1   CPU request, held until CPU_ACK
//    CPU_WE      in   1   1 = write, 0 = read
//    CPU_ADDR    in  13   CPU byte address
//    CPU_WDATA   in   8   CPU write data
//    CPU_ACK     out  1   CPU granted this cycle
//    CPU_VALID   out  1   CPU_RDATA carries fresh read data
//    CPU_RDATA   out  8   CPU read data (held between VALID pulses)
//    RAM_ADDR    out 13   VRAM address
//    RAM_WE      out  1   VRAM write enable
//    RAM_WDATA   out  8   VRAM write data
//    RAM_RDATA   in   8   VRAM read data, one-cycle registered latency
// ============================================================================
module vram_arbiter #(
  parameter int unsigned DEPTH      = 7168,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        CLK_25MHZ,
  input  logic        RESET_N,
  input  logic        VID_REQ,
  input  logic [12:0] VID_ADDR,
  output logic        VID_ACK,
  output logic        VID_VALID,
  output logic [7:0]  VID_DATA,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [12:0] CPU_ADDR,
  input  logic [7:0]  CPU_WDATA,
  output logic        CPU_ACK,
  output logic        CPU_VALID,
  output logic [7:0]  CPU_RDATA,
  output logic [12:0] RAM_ADDR,
  output logic        RAM_WE,
  output logic [7:0]  RAM_WDATA,
  input  logic [7:0]  RAM_RDATA
);

  localparam logic [7:0] c_starve_limit = 8'(STARVE_MAX);

  logic [7:0] r_starve;
  logic       r_vid_pend;
  logic       r_vid_oob;
  logic       r_cpu_pend;
  logic       r_cpu_oob;
  logic [7:0] r_vid_hold;
  logic [7:0] r_cpu_hold;

  logic       w_vid_grant;
  logic       w_cpu_grant;
  logic       w_vid_oob;
  logic       w_cpu_oob;

  assign w_vid_oob = 32'(VID_ADDR) >= DEPTH;
  assign w_cpu_oob = 32'(CPU_ADDR) >= DEPTH;

  // Grant decision: reset blocks everything; the CPU wins when video is idle
  // or when it has been denied STARVE_MAX times in a row.
  always_comb begin
    w_vid_grant = 1'b0;
    w_cpu_grant = 1'b0;
    if (RESET_N) begin
      if (CPU_REQ && (!VID_REQ || (r_starve == c_starve_limit))) begin
        w_cpu_grant = 1'b1;
      end else if (VID_REQ) begin
        w_vid_grant = 1'b1;
      end
    end
  end

  assign VID_ACK = w_vid_grant;
  assign CPU_ACK = w_cpu_grant;

  // RAM port mux. Out-of-range accesses still take the slot but are steered
  // to address 0 with writes suppressed.
  always_comb begin
    RAM_ADDR  = '0;
    RAM_WE    = 1'b0;
    RAM_WDATA = '0;
    if (w_vid_grant) begin
      if (!w_vid_oob) begin
        RAM_ADDR = VID_ADDR;
      end
    end else if (w_cpu_grant) begin
      RAM_WDATA = CPU_WDATA;
      if (!w_cpu_oob) begin
        RAM_ADDR = CPU_ADDR;
        RAM_WE   = CPU_WE;
      end
    end
  end

  // Starve counter: counts consecutive cycles where the CPU waited behind video.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      r_starve <= '0;
    end else if (!CPU_REQ || w_cpu_grant) begin
      r_starve <= '0;
    end else if (w_vid_grant && (r_starve != c_starve_limit)) begin
      r_starve <= r_starve + 8'd1;
    end
  end

  // Read-return pipeline: remember which reads are in flight and whether
  // they were out of range (those return 0x00 instead of RAM data).
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      r_vid_pend <= 1'b0;
      r_vid_oob  <= 1'b0;
      r_cpu_pend <= 1'b0;
      r_cpu_oob  <= 1'b0;
      r_vid_hold <= '0;
      r_cpu_hold <= '0;
    end else begin
      r_vid_pend <= w_vid_grant;
      r_vid_oob  <= w_vid_oob;
      r_cpu_pend <= w_cpu_grant && !CPU_WE;
      r_cpu_oob  <= w_cpu_oob;
      r_vid_hold <= VID_DATA;
      r_cpu_hold <= CPU_RDATA;
    end
  end

  // VALID is also masked by RESET_N so a read caught by reset never pulses.
  assign VID_VALID = r_vid_pend && RESET_N;
  assign CPU_VALID = r_cpu_pend && RESET_N;

  assign VID_DATA  = VID_VALID ? (r_vid_oob ? 8'h00 : RAM_RDATA) : r_vid_hold;
  assign CPU_RDATA = CPU_VALID ? (r_cpu_oob ? 8'h00 : RAM_RDATA) : r_cpu_hold;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Self-checking bench for vram_arbiter. A bench-side RAM serves
//             the DUT; a behavioural model (priority rule, denial count,
//             shadow memory, one-cycle read return) predicts every output on
//             every cycle, and directed literal checks pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  localparam int DEPTH_TB  = 7168;
  localparam int STARVE_TB = 8;

  logic        CLK_25MHZ = 1'b0;
  logic        RESET_N   = 1'b0;
  logic        VID_REQ   = 1'b0;
  logic [12:0] VID_ADDR  = '0;
  logic        VID_ACK;
  logic        VID_VALID;
  logic [7:0]  VID_DATA;
  logic        CPU_REQ   = 1'b0;
  logic        CPU_WE    = 1'b0;
  logic [12:0] CPU_ADDR  = '0;
  logic [7:0]  CPU_WDATA = '0;
  logic        CPU_ACK;
  logic        CPU_VALID;
  logic [7:0]  CPU_RDATA;
  logic [12:0] RAM_ADDR;
  logic        RAM_WE;
  logic [7:0]  RAM_WDATA;
  logic [7:0]  RAM_RDATA = '0;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  vram_arbiter #(.DEPTH(DEPTH_TB), .STARVE_MAX(STARVE_TB)) dut (
    .CLK_25MHZ(CLK_25MHZ), .RESET_N(RESET_N),
    .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_ACK(VID_ACK),
    .VID_VALID(VID_VALID), .VID_DATA(VID_DATA),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR),
    .CPU_WDATA(CPU_WDATA), .CPU_ACK(CPU_ACK), .CPU_VALID(CPU_VALID),
    .CPU_RDATA(CPU_RDATA), .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE),
    .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
  );

  always #20 CLK_25MHZ = ~CLK_25MHZ;

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Bench RAM: registered read, write on RAM_WE.
  logic [7:0] mem [0:8191];
  initial for (int i = 0; i < 8192; i++) mem[i] = pat(i);
  always @(posedge CLK_25MHZ) begin
    if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
    RAM_RDATA <= mem[RAM_ADDR];
  end

  // ---------------- behavioural model ----------------
  logic [7:0] shadow [0:8191];
  initial for (int i = 0; i < 8192; i++) shadow[i] = pat(i);

  int         m_denials = 0;
  bit         m_vpend = 0, m_cpend = 0;
  logic [7:0] m_vnext = '0, m_cnext = '0, m_vhold = '0, m_chold = '0;
  bit         g_vack = 0, g_cack = 0, g_cwe = 0, g_creq = 0;
  int         g_vaddr = 0, g_caddr = 0;
  logic [7:0] g_cwdata = '0, g_vdata = '0, g_cdata = '0;

  always @(negedge CLK_25MHZ) begin
    if (chk_en) begin
      bit         ev_ack, ec_ack, e_we, ev_val, ec_val;
      logic [12:0] e_addr;
      logic [7:0] e_wd, ev_d, ec_d;
      logic [41:0] act, exp_v;
      ev_ack = RESET_N && VID_REQ && !(CPU_REQ && m_denials == STARVE_TB);
      ec_ack = RESET_N && CPU_REQ && !ev_ack;
      e_addr = '0; e_we = 0; e_wd = '0;
      if (ev_ack) begin
        if (int'(VID_ADDR) < DEPTH_TB) e_addr = VID_ADDR;
      end else if (ec_ack) begin
        e_wd = CPU_WDATA;
        if (int'(CPU_ADDR) < DEPTH_TB) begin
          e_addr = CPU_ADDR;
          e_we   = CPU_WE;
        end
      end
      ev_val = RESET_N && m_vpend;
      ec_val = RESET_N && m_cpend;
      ev_d   = ev_val ? m_vnext : m_vhold;
      ec_d   = ec_val ? m_cnext : m_chold;
      act   = {VID_ACK, CPU_ACK, RAM_WE, RAM_ADDR, RAM_WDATA,
               VID_VALID, VID_DATA, CPU_VALID, CPU_RDATA};
      exp_v = {ev_ack, ec_ack, e_we, e_addr, e_wd, ev_val, ev_d, ec_val, ec_d};
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t actual=%h expected=%h", $time, act, exp_v);
      end
      g_vack = ev_ack; g_cack = ec_ack; g_cwe = CPU_WE; g_creq = CPU_REQ;
      g_vaddr = int'(VID_ADDR); g_caddr = int'(CPU_ADDR);
      g_cwdata = CPU_WDATA; g_vdata = ev_d; g_cdata = ec_d;
    end
  end

  always @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      m_denials = 0; m_vpend = 0; m_cpend = 0; m_vhold = '0; m_chold = '0;
    end else begin
      m_vhold = g_vdata;
      m_chold = g_cdata;
      m_vpend = g_vack;
      m_vnext = (g_vaddr < DEPTH_TB) ? shadow[g_vaddr] : 8'h00;
      m_cpend = g_cack && !g_cwe;
      m_cnext = (g_caddr < DEPTH_TB) ? shadow[g_caddr] : 8'h00;
      if (g_cack && g_cwe && g_caddr < DEPTH_TB) shadow[g_caddr] = g_cwdata;
      if (!g_creq || g_cack) m_denials = 0;
      else if (g_vack && m_denials < STARVE_TB) m_denials = m_denials + 1;
    end
    g_vack = 0; g_cack = 0; g_creq = 0;
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK_25MHZ); #1;
  endtask

  task automatic sample();
    @(negedge CLK_25MHZ);
  endtask

  logic [26:0] cpu_pat;

  initial begin
    // Reset with both requests high: nothing granted.
    next_cycle();
    chk_en = 1'b1;
    VID_REQ = 1; CPU_REQ = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rst_acks", {30'd0, VID_ACK, CPU_ACK}, 32'd0);
      check("rst_ram", {18'd0, RAM_WE, RAM_ADDR}, 32'd0);
      next_cycle();
    end
    VID_REQ = 0; CPU_REQ = 0; RESET_N = 1;
    sample();
    check("rst_data", {16'd0, VID_DATA, CPU_RDATA}, 32'd0);

    // CPU write 0x5A -> 0x0400
    next_cycle();
    CPU_REQ = 1; CPU_WE = 1; CPU_ADDR = 13'h0400; CPU_WDATA = 8'h5A;
    sample();
    check("wr_ack", {31'd0, CPU_ACK}, 32'd1);
    check("wr_ram", {10'd0, RAM_WE, RAM_ADDR, RAM_WDATA}, {10'd0, 1'b1, 13'h0400, 8'h5A});
    next_cycle();
    CPU_REQ = 0; CPU_WE = 0;
    sample();
    check("wr_no_valid", {31'd0, CPU_VALID}, 32'd0);

    // CPU read back 0x0400
    next_cycle();
    CPU_REQ = 1; CPU_ADDR = 13'h0400;
    sample();
    check("rd_ack", {30'd0, CPU_ACK, RAM_WE}, 32'd2);
    next_cycle();
    CPU_REQ = 0;
    sample();
    check("rd_valid", {23'd0, CPU_VALID, CPU_RDATA}, {23'd0, 1'b1, 8'h5A});
    next_cycle();
    sample();
    check("rd_hold", {23'd0, CPU_VALID, CPU_RDATA}, {23'd0, 1'b0, 8'h5A});

    // Video streaming 0x0000..0x000F
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      VID_REQ = 1; VID_ADDR = 13'(i);
      sample();
      check("stream_ack", {31'd0, VID_ACK}, 32'd1);
    end
    next_cycle();
    VID_REQ = 0;
    sample();
    check("stream_last", {23'd0, VID_VALID, VID_DATA}, {23'd0, 1'b1, 8'h36});

    // Both held: 8 video grants, then 1 CPU grant, repeating
    next_cycle();
    VID_REQ = 1; VID_ADDR = 13'h0010; CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 13'h0400;
    cpu_pat = '0;
    for (int i = 0; i < 27; i++) begin
      sample();
      cpu_pat[i] = CPU_ACK;
      next_cycle();
    end
    check("starve_pattern", {5'd0, cpu_pat}, 32'h0402_0100);
    VID_REQ = 0; CPU_REQ = 0;

    // Abandoned CPU write behind video: no RAM side effect
    next_cycle();
    VID_REQ = 1; VID_ADDR = 13'h0020;
    CPU_REQ = 1; CPU_WE = 1; CPU_ADDR = 13'h0500; CPU_WDATA = 8'hEE;
    sample();
    check("abandon_vid_wins", {30'd0, VID_ACK, CPU_ACK}, 32'd2);
    next_cycle();
    VID_REQ = 0; CPU_REQ = 0; CPU_WE = 0;
    next_cycle();
    CPU_REQ = 1; CPU_ADDR = 13'h0500;
    next_cycle();
    CPU_REQ = 0;
    sample();
    check("abandon_readback", {23'd0, CPU_VALID, CPU_RDATA}, {23'd0, 1'b1, 8'h0B});

    // Out-of-range accesses
    next_cycle();
    CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 13'h1C00;
    sample();
    check("oob_rd_ack", {17'd0, CPU_ACK, RAM_WE, RAM_ADDR}, {17'd0, 1'b1, 1'b0, 13'h0});
    next_cycle();
    CPU_WE = 1; CPU_ADDR = 13'h1FFF; CPU_WDATA = 8'h77;
    sample();
    check("oob_rd_valid", {23'd0, CPU_VALID, CPU_RDATA}, {23'd0, 1'b1, 8'h00});
    check("oob_wr", {17'd0, CPU_ACK, RAM_WE, RAM_ADDR}, {17'd0, 1'b1, 1'b0, 13'h0});
    next_cycle();
    CPU_REQ = 0; CPU_WE = 0;
    sample();
    check("oob_wr_no_valid", {31'd0, CPU_VALID}, 32'd0);

    // Video read granted, reset asserted before the next edge
    next_cycle();
    VID_REQ = 1; VID_ADDR = 13'h0003;
    sample();
    check("rst_rd_ack", {31'd0, VID_ACK}, 32'd1);
    #1 RESET_N = 0;
    next_cycle();
    sample();
    check("rst_rd_novalid", {23'd0, VID_VALID, VID_DATA}, 32'd0);
    next_cycle();
    RESET_N = 1;
    sample();
    check("rst_release_ack", {31'd0, VID_ACK}, 32'd1);
    next_cycle();
    VID_REQ = 0;
    sample();
    check("rst_release_data", {23'd0, VID_VALID, VID_DATA}, {23'd0, 1'b1, 8'h7A});

    next_cycle();
    next_cycle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  DEPTH, 7168, number of addressable VRAM bytes
  STARVE_MAX, 8, consecutive CPU denials before CPU is forced through (range 1..255)
REQ-002 Ports SHALL be, one per line:
  CLK_25MHZ  in  1  sole clock, all logic on rising edge
  RESET_N  in  1  reset, synchronous, active-low
  VID_REQ  in  1  video scanout read request, held until VID_ACK
  VID_ADDR  in  13  video read byte address
  VID_ACK  out  1  video request granted this cycle
  VID_VALID  out  1  VID_DATA carries fresh read data
  VID_DATA  out  8  video read data
  CPU_REQ  in  1  CPU access request, held until CPU_ACK
  CPU_WE  in  1  1 = write, 0 = read
  CPU_ADDR  in  13  CPU byte address
  CPU_WDATA  in  8  CPU write data
  CPU_ACK  out  1  CPU request granted this cycle
  CPU_VALID  out  1  CPU_RDATA carries fresh read data
  CPU_RDATA  out  8  CPU read data
  RAM_ADDR  out  13  single-port VRAM address
  RAM_WE  out  1  VRAM write enable
  RAM_WDATA  out  8  VRAM write data
  RAM_RDATA  in  8  VRAM read data, one-cycle registered latency

Function
REQ-003 At most one of VID_ACK, CPU_ACK SHALL be high in any cycle.
REQ-004 Grant SHALL be combinational from current-cycle REQ inputs and registered state; RAM_ADDR/RAM_WE/RAM_WDATA SHALL be driven in the same cycle as the ACK.
REQ-005 Priority: video wins when both request, except when starve counter == STARVE_MAX, in which case CPU wins.
REQ-006 Starve counter (8 bit): +1 when CPU_REQ high and video granted; cleared when CPU granted or CPU_REQ low; saturates at STARVE_MAX.
REQ-007 Video grant: RAM_ADDR = VID_ADDR, RAM_WE = 0.
REQ-008 CPU grant: RAM_ADDR = CPU_ADDR, RAM_WE = CPU_WE, RAM_WDATA = CPU_WDATA.
REQ-009 No grant: RAM_ADDR = 0, RAM_WE = 0, RAM_WDATA = 0.
REQ-010 Read latency: VID_VALID/CPU_VALID SHALL pulse exactly one cycle after the granting read ACK, for one cycle, with data = RAM_RDATA of that cycle.
REQ-011 CPU write grants SHALL produce no CPU_VALID pulse.
REQ-012 VID_DATA/CPU_RDATA SHALL hold their last valid value between VALID pulses.
REQ-013 Address >= DEPTH: request still ACKed and consumes the slot; RAM_WE forced 0, RAM_ADDR = 0; read returns data 0x00 with the normal VALID pulse.
REQ-014 Back-to-back grants to the same requester on consecutive cycles SHALL be supported (one access per cycle, full throughput).
REQ-015 A requester deasserting REQ without ACK SHALL abandon the request with no RAM side effect.

Reset
REQ-016 While RESET_N = 0 at a clock edge: starve counter = 0, VALID pipelines cleared, VID_DATA = CPU_RDATA = 0x00.
REQ-017 While RESET_N = 0: VID_ACK = CPU_ACK = 0, RAM_WE = 0, RAM_ADDR = 0, regardless of REQ inputs.
REQ-018 A read granted in the cycle before reset asserts SHALL NOT produce a VALID pulse; first grant is possible in the first cycle with RESET_N = 1.

Verification
REQ-019 CPU write 0x5A to 0x0400 alone -> CPU_ACK same cycle, RAM_WE=1, RAM_ADDR=0x0400, RAM_WDATA=0x5A; no CPU_VALID.
REQ-020 CPU read 0x0400 after REQ-019 (RAM model) -> CPU_VALID one cycle after ACK, CPU_RDATA=0x5A, held afterwards.
REQ-021 VID_REQ and CPU_REQ (read) held continuously, STARVE_MAX=8 -> 8 video grants, then 1 CPU grant, pattern repeats; never both ACKs high.
REQ-022 CPU read 0x1C00 (= DEPTH) -> ACK, RAM_WE=0, RAM_ADDR=0, CPU_VALID next cycle with 0x00; CPU write 0x1FFF -> no RAM write.
REQ-023 Video read granted, RESET_N low next edge -> no VID_VALID, VID_DATA=0x00, counter 0; after release, pending VID_REQ ACKed in first cycle.
REQ-024 Video streaming reads 0x0000..0x000F every cycle, no CPU -> 16 consecutive ACKs, 16 VALID pulses each one cycle later with matching data.
